// File: rtl/calendar_clock.sv
// calendar_clock: seconds-through-years calendar counter driven by a
// one-second strobe. All carries ripple within a single clock edge.
// Supports a synchronous load, optional Gregorian month lengths with
// leap-year February, and an hour:minute alarm.
//
// Ports:
//   clk        - system clock, rising edge
//   reset      - synchronous active-high clear of all state
//   tick       - one-second strobe, one clk wide
//   set_en     - load set_* values this edge (overrides tick)
//   set_*      - load values; out-of-range fields load 0
//   alarm_en   - enables alarm comparison
//   alarm_hour - alarm hour
//   alarm_min  - alarm minute
//   seconds..years - registered time (days and months are 0-based)
//   alarm      - one-cycle pulse when a tick reaches alarm_hour:alarm_min:00
//   year_wrap  - one-cycle pulse when years wraps to 0
module calendar_clock #(
  parameter int unsigned SEC_PER_MIN     = 60,
  parameter int unsigned MIN_PER_HOUR    = 60,
  parameter int unsigned HOURS_PER_DAY   = 24,
  parameter int unsigned DAYS_PER_MONTH  = 30,
  parameter int unsigned MONTHS_PER_YEAR = 12,
  parameter int unsigned GREGORIAN       = 0,
  parameter int unsigned YEAR_W          = 7,
  localparam int unsigned MONTHS  = (GREGORIAN != 0) ? 12 : MONTHS_PER_YEAR,
  localparam int unsigned DAY_MAX = (GREGORIAN != 0) ? 31 : DAYS_PER_MONTH,
  localparam int unsigned SW  = $clog2(SEC_PER_MIN),
  localparam int unsigned MW  = $clog2(MIN_PER_HOUR),
  localparam int unsigned HW  = $clog2(HOURS_PER_DAY),
  localparam int unsigned DW  = $clog2(DAY_MAX),
  localparam int unsigned MOW = $clog2(MONTHS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic              set_en,
  input  logic [SW-1:0]     set_sec,
  input  logic [MW-1:0]     set_min,
  input  logic [HW-1:0]     set_hour,
  input  logic [DW-1:0]     set_day,
  input  logic [MOW-1:0]    set_month,
  input  logic [YEAR_W-1:0] set_year,
  input  logic              alarm_en,
  input  logic [HW-1:0]     alarm_hour,
  input  logic [MW-1:0]     alarm_min,
  output logic [SW-1:0]     seconds,
  output logic [MW-1:0]     minutes,
  output logic [HW-1:0]     hours,
  output logic [DW-1:0]     days,
  output logic [MOW-1:0]    months,
  output logic [YEAR_W-1:0] years,
  output logic              alarm,
  output logic              year_wrap
);

  // Number of days in month m of year y (year 0 is 2000, so y%4==0 is leap).
  function automatic int unsigned month_len(input logic [MOW-1:0]    m,
                                            input logic [YEAR_W-1:0] y);
    int unsigned len;
    if (GREGORIAN == 0) begin
      len = DAYS_PER_MONTH;
    end else begin
      case (32'(m))
        1:             len = ((32'(y) % 4) == 0) ? 29 : 28;
        3, 5, 8, 10:   len = 30;
        default:       len = 31;
      endcase
    end
    return len;
  endfunction

  // Carry out of each field on a tick, and the resulting next values.
  logic sec_c, min_c, hour_c, day_c, mon_c, year_c;
  logic [SW-1:0]     sec_inc;
  logic [MW-1:0]     min_inc;
  logic [HW-1:0]     hour_inc;
  logic [DW-1:0]     day_inc;
  logic [MOW-1:0]    mon_inc;
  logic [YEAR_W-1:0] year_inc;
  logic              alarm_hit;

  // Clamped load values.
  logic [SW-1:0]  ld_sec;
  logic [MW-1:0]  ld_min;
  logic [HW-1:0]  ld_hour;
  logic [DW-1:0]  ld_day;
  logic [MOW-1:0] ld_month;

  always_comb begin
    sec_c  = (32'(seconds) == SEC_PER_MIN - 1);
    min_c  = sec_c  && (32'(minutes) == MIN_PER_HOUR - 1);
    hour_c = min_c  && (32'(hours) == HOURS_PER_DAY - 1);
    day_c  = hour_c && (32'(days) == month_len(months, years) - 1);
    mon_c  = day_c  && (32'(months) == MONTHS - 1);
    year_c = mon_c  && (years == '1);

    sec_inc  = sec_c ? '0 : seconds + SW'(1);
    min_inc  = !sec_c  ? minutes : (min_c  ? '0 : minutes + MW'(1));
    hour_inc = !min_c  ? hours   : (hour_c ? '0 : hours + HW'(1));
    day_inc  = !hour_c ? days    : (day_c  ? '0 : days + DW'(1));
    mon_inc  = !day_c  ? months  : (mon_c  ? '0 : months + MOW'(1));
    // Years span the full field width, so natural overflow is the wrap.
    year_inc = !mon_c  ? years   : years + YEAR_W'(1);

    alarm_hit = alarm_en && (hour_inc == alarm_hour) &&
                (min_inc == alarm_min) && (sec_inc == '0);
  end

  always_comb begin
    ld_sec   = (32'(set_sec)   >= SEC_PER_MIN)   ? '0 : set_sec;
    ld_min   = (32'(set_min)   >= MIN_PER_HOUR)  ? '0 : set_min;
    ld_hour  = (32'(set_hour)  >= HOURS_PER_DAY) ? '0 : set_hour;
    ld_month = (32'(set_month) >= MONTHS)        ? '0 : set_month;
    // Day validity depends on the month/year being loaded, not the current one.
    ld_day   = (32'(set_day) >= month_len(ld_month, set_year)) ? '0 : set_day;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seconds   <= '0;
      minutes   <= '0;
      hours     <= '0;
      days      <= '0;
      months    <= '0;
      years     <= '0;
      alarm     <= 1'b0;
      year_wrap <= 1'b0;
    end else if (set_en) begin
      seconds   <= ld_sec;
      minutes   <= ld_min;
      hours     <= ld_hour;
      days      <= ld_day;
      months    <= ld_month;
      years     <= set_year;
      alarm     <= 1'b0;
      year_wrap <= 1'b0;
    end else if (tick) begin
      seconds   <= sec_inc;
      minutes   <= min_inc;
      hours     <= hour_inc;
      days      <= day_inc;
      months    <= mon_inc;
      years     <= year_inc;
      alarm     <= alarm_hit;
      year_wrap <= year_c;
    end else begin
      alarm     <= 1'b0;
      year_wrap <= 1'b0;
    end
  end

endmodule

// File: tb/tb_calendar_clock.sv
// Bench for calendar_clock: three instances (default, Gregorian with 2-bit
// years, and a tiny Gregorian clock whose years roll quickly) share one
// stimulus stream and are checked against a behavioural model that tracks
// second-of-day, day, month and year as plain integers.
module tb_calendar_clock;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, tick, set_en, alarm_en;
  logic [6:0] set_sec, set_min, set_hour, set_day, set_month, set_year;
  logic [6:0] alarm_hour, alarm_min;

  logic [5:0] d_sec, d_min;
  logic [4:0] d_hour, d_day;
  logic [3:0] d_mon;
  logic [6:0] d_year;
  logic       d_alarm, d_yw;

  logic [5:0] g_sec, g_min;
  logic [4:0] g_hour, g_day;
  logic [3:0] g_mon;
  logic [1:0] g_year;
  logic       g_alarm, g_yw;

  logic [1:0] s_sec, s_min;
  logic [0:0] s_hour;
  logic [4:0] s_day;
  logic [3:0] s_mon;
  logic [1:0] s_year;
  logic       s_alarm, s_yw;

  calendar_clock u_d (
    .clk(clk), .reset(reset), .tick(tick), .set_en(set_en),
    .set_sec(set_sec[5:0]), .set_min(set_min[5:0]), .set_hour(set_hour[4:0]),
    .set_day(set_day[4:0]), .set_month(set_month[3:0]), .set_year(set_year[6:0]),
    .alarm_en(alarm_en), .alarm_hour(alarm_hour[4:0]), .alarm_min(alarm_min[5:0]),
    .seconds(d_sec), .minutes(d_min), .hours(d_hour), .days(d_day),
    .months(d_mon), .years(d_year), .alarm(d_alarm), .year_wrap(d_yw)
  );

  calendar_clock #(.GREGORIAN(1), .YEAR_W(2)) u_g (
    .clk(clk), .reset(reset), .tick(tick), .set_en(set_en),
    .set_sec(set_sec[5:0]), .set_min(set_min[5:0]), .set_hour(set_hour[4:0]),
    .set_day(set_day[4:0]), .set_month(set_month[3:0]), .set_year(set_year[1:0]),
    .alarm_en(alarm_en), .alarm_hour(alarm_hour[4:0]), .alarm_min(alarm_min[5:0]),
    .seconds(g_sec), .minutes(g_min), .hours(g_hour), .days(g_day),
    .months(g_mon), .years(g_year), .alarm(g_alarm), .year_wrap(g_yw)
  );

  calendar_clock #(.SEC_PER_MIN(4), .MIN_PER_HOUR(3), .HOURS_PER_DAY(2),
                   .GREGORIAN(1), .YEAR_W(2)) u_s (
    .clk(clk), .reset(reset), .tick(tick), .set_en(set_en),
    .set_sec(set_sec[1:0]), .set_min(set_min[1:0]), .set_hour(set_hour[0:0]),
    .set_day(set_day[4:0]), .set_month(set_month[3:0]), .set_year(set_year[1:0]),
    .alarm_en(alarm_en), .alarm_hour(alarm_hour[0:0]), .alarm_min(alarm_min[1:0]),
    .seconds(s_sec), .minutes(s_min), .hours(s_hour), .days(s_day),
    .months(s_mon), .years(s_year), .alarm(s_alarm), .year_wrap(s_yw)
  );

  // Per-instance configuration seen by the model.
  int P_SEC[3]  = '{60, 60, 4};
  int P_MIN[3]  = '{60, 60, 3};
  int P_HR[3]   = '{24, 24, 2};
  int P_DPM[3]  = '{30, 30, 30};
  int P_GREG[3] = '{0, 1, 1};
  int P_YW[3]   = '{7, 2, 2};
  int MDAYS[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
  string FNAME[8] = '{"seconds", "minutes", "hours", "days", "months",
                      "years", "alarm", "year_wrap"};

  int m_sod[3], m_day[3], m_mon[3], m_year[3], m_al[3], m_yw[3];

  int vectors = 0;
  int miscompares = 0;
  bit chk_on = 1'b0;

  function automatic int tr(input int v, input int modulus);
    return v & ((1 << $clog2(modulus)) - 1);
  endfunction

  function automatic int mlen(input int i, input int mo, input int y);
    if (P_GREG[i] == 0) return P_DPM[i];
    return MDAYS[mo] + ((mo == 1 && (y % 4) == 0) ? 1 : 0);
  endfunction

  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      int spd, dmax, ymask, s, mn, h, ah, am;
      spd   = P_SEC[i] * P_MIN[i] * P_HR[i];
      dmax  = (P_GREG[i] != 0) ? 31 : P_DPM[i];
      ymask = (1 << P_YW[i]) - 1;
      m_al[i] = 0;
      m_yw[i] = 0;
      if (reset) begin
        m_sod[i] = 0; m_day[i] = 0; m_mon[i] = 0; m_year[i] = 0;
      end else if (set_en) begin
        s  = tr(int'(set_sec), P_SEC[i]);   if (s >= P_SEC[i]) s = 0;
        mn = tr(int'(set_min), P_MIN[i]);   if (mn >= P_MIN[i]) mn = 0;
        h  = tr(int'(set_hour), P_HR[i]);   if (h >= P_HR[i]) h = 0;
        m_mon[i] = tr(int'(set_month), 12);
        if (m_mon[i] >= 12) m_mon[i] = 0;
        m_year[i] = int'(set_year) & ymask;
        m_day[i] = tr(int'(set_day), dmax);
        if (m_day[i] >= mlen(i, m_mon[i], m_year[i])) m_day[i] = 0;
        m_sod[i] = (h * P_MIN[i] + mn) * P_SEC[i] + s;
      end else if (tick) begin
        m_sod[i]++;
        if (m_sod[i] == spd) begin
          m_sod[i] = 0;
          m_day[i]++;
          if (m_day[i] == mlen(i, m_mon[i], m_year[i])) begin
            m_day[i] = 0;
            m_mon[i]++;
            if (m_mon[i] == 12) begin
              m_mon[i] = 0;
              m_year[i] = (m_year[i] + 1) & ymask;
              m_yw[i] = (m_year[i] == 0) ? 1 : 0;
            end
          end
        end
        ah = tr(int'(alarm_hour), P_HR[i]);
        am = tr(int'(alarm_min), P_MIN[i]);
        if (alarm_en && ah < P_HR[i] && am < P_MIN[i] &&
            m_sod[i] == (ah * P_MIN[i] + am) * P_SEC[i])
          m_al[i] = 1;
      end
    end
  endtask

  // Every-cycle comparison of all instances against the model.
  always @(negedge clk) begin
    int got[3][8];
    int exp[8];
    if (chk_on) begin
      got[0] = '{int'(d_sec), int'(d_min), int'(d_hour), int'(d_day),
                 int'(d_mon), int'(d_year), int'(d_alarm), int'(d_yw)};
      got[1] = '{int'(g_sec), int'(g_min), int'(g_hour), int'(g_day),
                 int'(g_mon), int'(g_year), int'(g_alarm), int'(g_yw)};
      got[2] = '{int'(s_sec), int'(s_min), int'(s_hour), int'(s_day),
                 int'(s_mon), int'(s_year), int'(s_alarm), int'(s_yw)};
      for (int i = 0; i < 3; i++) begin
        exp[0] = m_sod[i] % P_SEC[i];
        exp[1] = (m_sod[i] / P_SEC[i]) % P_MIN[i];
        exp[2] = m_sod[i] / (P_SEC[i] * P_MIN[i]);
        exp[3] = m_day[i];
        exp[4] = m_mon[i];
        exp[5] = m_year[i];
        exp[6] = m_al[i];
        exp[7] = m_yw[i];
        for (int f = 0; f < 8; f++) begin
          vectors++;
          if (got[i][f] != exp[f]) begin
            miscompares++;
            $display("FAIL model %s inst%0d @%0t: got %0d expected %0d",
                     FNAME[f], i, $time, got[i][f], exp[f]);
          end
        end
      end
    end
  end

  task automatic pin(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL pin %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_set(input int s, input int mn, input int h, input int d,
                        input int mo, input int y, input bit t);
    set_en = 1'b1; tick = t;
    set_sec = 7'(s); set_min = 7'(mn); set_hour = 7'(h);
    set_day = 7'(d); set_month = 7'(mo); set_year = 7'(y);
    cyc();
    set_en = 1'b0; tick = 1'b0;
  endtask

  task automatic do_tick();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; set_en = 1'b0; alarm_en = 1'b0;
    set_sec = '0; set_min = '0; set_hour = '0; set_day = '0;
    set_month = '0; set_year = '0; alarm_hour = '0; alarm_min = '0;
    cyc();
    reset = 1'b0;
    chk_on = 1'b1;

    // Reset with a coincident tick clears arbitrary state.
    do_set(12, 34, 5, 6, 7, 8, 0);
    reset = 1'b1; tick = 1'b1;
    cyc();
    reset = 1'b0; tick = 1'b0;
    pin("reset sec", int'(d_sec), 0);
    pin("reset hour", int'(d_hour), 0);
    pin("reset year", int'(d_year), 0);
    pin("reset alarm", int'(d_alarm), 0);

    // Full ripple in one edge.
    do_set(59, 59, 23, 29, 11, 5, 0);
    do_tick();
    pin("ripple sec", int'(d_sec), 0);
    pin("ripple min", int'(d_min), 0);
    pin("ripple hour", int'(d_hour), 0);
    pin("ripple day", int'(d_day), 0);
    pin("ripple month", int'(d_mon), 0);
    pin("ripple year", int'(d_year), 6);

    // Leap February: year 4 truncates to 0 in the 2-bit instance (leap).
    do_set(59, 59, 23, 27, 1, 4, 0);
    do_tick();
    pin("leap day28", int'(g_day), 28);
    pin("leap month", int'(g_mon), 1);
    do_set(59, 59, 23, 28, 1, 4, 0);
    do_tick();
    pin("leap roll month", int'(g_mon), 2);
    pin("leap roll day", int'(g_day), 0);
    do_set(59, 59, 23, 27, 1, 5, 0);
    do_tick();
    pin("nonleap roll month", int'(g_mon), 2);
    pin("nonleap roll day", int'(g_day), 0);

    // Alarm.
    alarm_hour = 7'd7; alarm_min = 7'd30; alarm_en = 1'b1;
    do_set(59, 29, 7, 0, 0, 0, 0);
    do_tick();
    pin("alarm fire", int'(d_alarm), 1);
    pin("alarm min", int'(d_min), 30);
    cyc();
    pin("alarm one cycle", int'(d_alarm), 0);
    do_set(0, 30, 7, 0, 0, 0, 0);
    pin("alarm on set", int'(d_alarm), 0);
    alarm_en = 1'b0;
    do_set(59, 29, 7, 0, 0, 0, 0);
    do_tick();
    pin("alarm disabled", int'(d_alarm), 0);

    // Set clamping and set-over-tick priority.
    do_set(63, 0, 0, 0, 0, 0, 0);
    pin("clamp sec", int'(d_sec), 0);
    do_set(0, 0, 0, 30, 3, 0, 0);
    pin("clamp april day", int'(g_day), 0);
    pin("clamp d day", int'(d_day), 0);
    do_set(0, 0, 0, 30, 4, 0, 0);
    pin("may day30", int'(g_day), 30);
    do_set(30, 20, 10, 5, 4, 9, 1);
    pin("prio sec", int'(d_sec), 30);
    pin("prio min", int'(d_min), 20);
    pin("prio hour", int'(d_hour), 10);
    pin("prio day", int'(d_day), 5);
    pin("prio year", int'(d_year), 9);

    // Year wrap on the 2-bit-year instance.
    do_set(59, 59, 23, 30, 11, 3, 0);
    do_tick();
    pin("wrap year", int'(g_year), 0);
    pin("wrap pulse", int'(g_yw), 1);
    pin("wrap month", int'(g_mon), 0);
    cyc();
    pin("wrap pulse clear", int'(g_yw), 0);

    // Randomized run, checked every cycle by the model compare.
    for (int n = 0; n < 20000; n++) begin
      reset  = ($urandom_range(0, 499) == 0);
      set_en = ($urandom_range(0, 99) == 0);
      tick   = ($urandom_range(0, 7) != 0);
      if (set_en) begin
        if ($urandom_range(0, 1) == 1) begin
          set_sec = 7'd59; set_min = 7'd59; set_hour = 7'd23;
          set_day = 7'($urandom_range(26, 31));
          set_month = 7'($urandom_range(0, 12));
        end else begin
          set_sec = 7'($urandom_range(0, 63));
          set_min = 7'($urandom_range(0, 63));
          set_hour = 7'($urandom_range(0, 31));
          set_day = 7'($urandom_range(0, 31));
          set_month = 7'($urandom_range(0, 15));
        end
        set_year = 7'($urandom_range(0, 127));
      end
      if ($urandom_range(0, 199) == 0) begin
        alarm_en = ($urandom_range(0, 3) != 0);
        alarm_hour = 7'($urandom_range(0, 31));
        alarm_min = 7'($urandom_range(0, 63));
      end
      cyc();
    end
    reset = 1'b0; set_en = 1'b0; tick = 1'b0;
    cyc();
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
